// File: rtl/ieeedrv_rom_arbiter.sv
// Shares one synchronous drive ROM among NDR drive channels: each ph2 sweeps the
// requesting channels in index order and steers fixed-latency read data back.
module ieeedrv_rom_arbiter #(
  parameter int unsigned NDR = 4,
  parameter int unsigned AW  = 14,
  parameter int unsigned DW  = 8,
  parameter int unsigned LAT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ph2,
  input  logic [NDR-1:0]    drv_req,
  input  logic [NDR*AW-1:0] drv_addr,
  output logic [AW-1:0]     rom_addr,
  output logic              rom_rd,
  input  logic [DW-1:0]     rom_q,
  output logic [NDR*DW-1:0] drv_data,
  output logic [NDR-1:0]    drv_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  localparam int unsigned IW = (NDR > 1) ? $clog2(NDR) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NDR-1:0]         pend_q, pend_d;
  logic [LAT-1:0]         pvld_q, pvld_d;
  logic [LAT-1:0][IW-1:0] pidx_q, pidx_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   rd_q, rd_d;
  logic [NDR*DW-1:0]      data_q, data_d;
  logic [NDR-1:0]         valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;

  logic                   hit;
  logic [IW-1:0]          pick;
  logic [AW-1:0]          pick_addr;
  logic                   fin;

  // Lowest pending channel wins the next ROM slot.
  always_comb begin
    hit       = 1'b0;
    pick      = '0;
    pick_addr = '0;
    for (int i = int'(NDR) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        hit       = 1'b1;
        pick      = IW'(i);
        pick_addr = drv_addr[i*AW +: AW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    data_d  = data_q;
    valid_d = '0;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    pvld_d  = '0;
    pidx_d  = '0;
    fin     = (state_q == S_DRAIN) && (pvld_q == '0);

    // Index pipeline shifts every cycle; its oldest stage meets rom_q.
    for (int s = int'(LAT) - 1; s > 0; s--) begin
      pvld_d[s] = pvld_q[s-1];
      pidx_d[s] = pidx_q[s-1];
    end
    for (int c = 0; c < int'(NDR); c++) begin
      if (pvld_q[LAT-1] && (pidx_q[LAT-1] == IW'(c))) begin
        valid_d[c]         = 1'b1;
        data_d[c*DW +: DW] = rom_q;
      end
    end

    case (state_q)
      S_ISSUE: begin
        if (hit) begin
          addr_d    = pick_addr;
          rd_d      = 1'b1;
          pend_d    = pend_q & (pend_q - NDR'(1));
          pvld_d[0] = 1'b1;
          pidx_d[0] = pick;
        end
        if (pend_d == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fin) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_IDLE:  ;
      default: state_d = S_IDLE;
    endcase

    // A start always restarts the sweep; it only counts as overrun if the old
    // sweep was not finishing on this very edge.
    if (ph2) begin
      ovr_d   = busy_q && !fin;
      pend_d  = drv_req;
      state_d = S_ISSUE;
      done_d  = 1'b0;
    end
    busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      pvld_q  <= '0;
      pidx_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      pidx_q  <= pidx_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rom_addr  = addr_q;
  assign rom_rd    = rd_q;
  assign drv_data  = data_q;
  assign drv_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule
